// File: rtl/id_ex_pipe.sv
// Decode/execute pipeline register with flush, bubble/hold control,
// valid tracking and saturating bubble/hold performance counters.
module id_ex_pipe #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int OPW    = 8,
    parameter int SELW   = 3,
    parameter int STALLW = 6,
    parameter int STAGE  = 2,
    parameter int EXCW   = 32,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STALLW-1:0] stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [OPW-1:0]    id_aluop,
    input  logic [SELW-1:0]   id_alusel,
    input  logic [XLEN-1:0]   id_reg1,
    input  logic [XLEN-1:0]   id_reg2,
    input  logic [AW-1:0]     id_wd,
    input  logic              id_wreg,
    input  logic [XLEN-1:0]   id_link_address,
    input  logic              id_is_in_delayslot,
    input  logic              next_inst_in_delayslot_i,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [EXCW-1:0]   id_excepttype,
    output logic [OPW-1:0]    ex_aluop,
    output logic [SELW-1:0]   ex_alusel,
    output logic [XLEN-1:0]   ex_reg1,
    output logic [XLEN-1:0]   ex_reg2,
    output logic [AW-1:0]     ex_wd,
    output logic              ex_wreg,
    output logic [XLEN-1:0]   ex_link_address,
    output logic              ex_is_in_delayslot,
    output logic [XLEN-1:0]   ex_pc,
    output logic [EXCW-1:0]   ex_excepttype,
    output logic              ex_valid,
    output logic              is_in_delayslot_o,
    output logic [CNTW-1:0]   bubble_cnt,
    output logic [CNTW-1:0]   hold_cnt
);

    typedef struct packed {
        logic [OPW-1:0]  aluop;
        logic [SELW-1:0] alusel;
        logic [XLEN-1:0] reg1;
        logic [XLEN-1:0] reg2;
        logic [AW-1:0]   wd;
        logic            wreg;
        logic [XLEN-1:0] link_address;
        logic            is_in_delayslot;
        logic [XLEN-1:0] pc;
        logic [EXCW-1:0] excepttype;
        logic            valid;
    } ex_t;

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    ex_t             ex_q, ex_d, id_s;
    logic            dslot_q, dslot_d;
    logic [CNTW-1:0] bubble_q, bubble_d;
    logic [CNTW-1:0] hold_q, hold_d;
    logic            stall_id, stall_ex;

    assign stall_id = stall[STAGE];
    assign stall_ex = stall[STAGE+1];

    // An invalid slot must never write the register file or raise a trap.
    always_comb begin
        id_s                 = '0;
        id_s.aluop           = id_aluop;
        id_s.alusel          = id_alusel;
        id_s.reg1            = id_reg1;
        id_s.reg2            = id_reg2;
        id_s.wd              = id_wd;
        id_s.wreg            = id_wreg & id_valid;
        id_s.link_address    = id_link_address;
        id_s.is_in_delayslot = id_is_in_delayslot;
        id_s.pc              = id_pc;
        id_s.excepttype      = id_valid ? id_excepttype : '0;
        id_s.valid           = id_valid;
    end

    always_comb begin
        ex_d     = ex_q;
        dslot_d  = dslot_q;
        bubble_d = bubble_q;
        hold_d   = hold_q;
        if (flush) begin
            ex_d    = '0;
            dslot_d = 1'b0;
        end else if (!stall_id) begin
            ex_d    = id_s;
            dslot_d = next_inst_in_delayslot_i;
        end else if (!stall_ex) begin
            // Bubble keeps the delay-slot flag so it survives a decode stall.
            ex_d = '0;
            if (bubble_q != CNT_MAX) bubble_d = bubble_q + CNT_ONE;
        end else begin
            if (hold_q != CNT_MAX) hold_d = hold_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q     <= '0;
            dslot_q  <= 1'b0;
            bubble_q <= '0;
            hold_q   <= '0;
        end else begin
            ex_q     <= ex_d;
            dslot_q  <= dslot_d;
            bubble_q <= bubble_d;
            hold_q   <= hold_d;
        end
    end

    assign ex_aluop           = ex_q.aluop;
    assign ex_alusel          = ex_q.alusel;
    assign ex_reg1            = ex_q.reg1;
    assign ex_reg2            = ex_q.reg2;
    assign ex_wd              = ex_q.wd;
    assign ex_wreg            = ex_q.wreg;
    assign ex_link_address    = ex_q.link_address;
    assign ex_is_in_delayslot = ex_q.is_in_delayslot;
    assign ex_pc              = ex_q.pc;
    assign ex_excepttype      = ex_q.excepttype;
    assign ex_valid           = ex_q.valid;
    assign is_in_delayslot_o  = dslot_q;
    assign bubble_cnt         = bubble_q;
    assign hold_cnt           = hold_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe; counters are narrowed to 4 bits so
// saturation is reachable in a short run.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        id_valid;
    logic [7:0]  id_aluop;
    logic [2:0]  id_alusel;
    logic [31:0] id_reg1, id_reg2;
    logic [4:0]  id_wd;
    logic        id_wreg;
    logic [31:0] id_link_address;
    logic        id_is_in_delayslot;
    logic        next_inst_in_delayslot_i;
    logic [31:0] id_pc;
    logic [31:0] id_excepttype;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_reg1, ex_reg2;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_link_address;
    logic        ex_is_in_delayslot;
    logic [31:0] ex_pc;
    logic [31:0] ex_excepttype;
    logic        ex_valid;
    logic        is_in_delayslot_o;
    logic [3:0]  bubble_cnt, hold_cnt;

    int checks = 0;
    int fails  = 0;
    int bub_exp = 0;

    always #5 clk = ~clk;

    id_ex_pipe #(.CNTW(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_aluop(id_aluop), .id_alusel(id_alusel),
        .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd),
        .id_wreg(id_wreg), .id_link_address(id_link_address),
        .id_is_in_delayslot(id_is_in_delayslot),
        .next_inst_in_delayslot_i(next_inst_in_delayslot_i),
        .id_pc(id_pc), .id_excepttype(id_excepttype),
        .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
        .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd),
        .ex_wreg(ex_wreg), .ex_link_address(ex_link_address),
        .ex_is_in_delayslot(ex_is_in_delayslot), .ex_pc(ex_pc),
        .ex_excepttype(ex_excepttype), .ex_valid(ex_valid),
        .is_in_delayslot_o(is_in_delayslot_o),
        .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; stall = 0; flush = 0; id_valid = 1;
        id_aluop = 8'h21; id_alusel = 3'd5; id_reg1 = 32'hDEADBEEF;
        id_reg2 = 32'h1; id_wd = 5'd7; id_wreg = 1;
        id_link_address = 32'h44; id_is_in_delayslot = 1;
        next_inst_in_delayslot_i = 1; id_pc = 32'h100;
        id_excepttype = 32'h8;
        step(); step();
        checks++; if (ex_aluop !== 8'h0) begin fails++; $display("FAIL rst_aluop got %h exp 0", ex_aluop); end
        checks++; if (ex_reg1 !== 32'h0) begin fails++; $display("FAIL rst_reg1 got %h exp 0", ex_reg1); end
        checks++; if (ex_valid !== 1'b0 || ex_wreg !== 1'b0) begin fails++; $display("FAIL rst_valid_wreg got %b%b exp 00", ex_valid, ex_wreg); end
        checks++; if (ex_pc !== 32'h0 || ex_excepttype !== 32'h0 || ex_is_in_delayslot !== 1'b0) begin fails++; $display("FAIL rst_misc got pc=%h exc=%h ds=%b exp 0", ex_pc, ex_excepttype, ex_is_in_delayslot); end
        checks++; if (is_in_delayslot_o !== 1'b0) begin fails++; $display("FAIL rst_dslot got %b exp 0", is_in_delayslot_o); end
        checks++; if (bubble_cnt !== 4'd0 || hold_cnt !== 4'd0) begin fails++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", bubble_cnt, hold_cnt); end
        rst = 0;
        bub_exp = 0;
    endtask

    task automatic test_advance();
        id_valid = 1; id_reg1 = 32'h12345678; id_wd = 5'd5; id_wreg = 1;
        id_aluop = 8'h21; id_alusel = 3'd2; id_excepttype = 32'h80;
        id_pc = 32'h1000; id_link_address = 32'h1008;
        id_is_in_delayslot = 1; next_inst_in_delayslot_i = 0;
        step();
        checks++; if (ex_reg1 !== 32'h12345678) begin fails++; $display("FAIL adv_reg1 got %h exp 12345678", ex_reg1); end
        checks++; if (ex_wd !== 5'd5 || ex_wreg !== 1'b1) begin fails++; $display("FAIL adv_wd got %0d/%b exp 5/1", ex_wd, ex_wreg); end
        checks++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL adv_valid got %b exp 1", ex_valid); end
        checks++; if (ex_aluop !== 8'h21 || ex_alusel !== 3'd2) begin fails++; $display("FAIL adv_op got %h/%0d exp 21/2", ex_aluop, ex_alusel); end
        checks++; if (ex_pc !== 32'h1000 || ex_link_address !== 32'h1008) begin fails++; $display("FAIL adv_pc got %h/%h exp 1000/1008", ex_pc, ex_link_address); end
        checks++; if (ex_excepttype !== 32'h80 || ex_is_in_delayslot !== 1'b1) begin fails++; $display("FAIL adv_exc got %h/%b exp 80/1", ex_excepttype, ex_is_in_delayslot); end
        id_valid = 0; id_wreg = 1; id_reg1 = 32'h0BADF00D;
        step();
        checks++; if (ex_wreg !== 1'b0 || ex_excepttype !== 32'h0) begin fails++; $display("FAIL adv_inv_gate got %b/%h exp 0/0", ex_wreg, ex_excepttype); end
        checks++; if (ex_valid !== 1'b0 || ex_reg1 !== 32'h0BADF00D) begin fails++; $display("FAIL adv_inv_load got %b/%h exp 0/0badf00d", ex_valid, ex_reg1); end
    endtask

    task automatic test_bubble_dslot();
        id_valid = 1; next_inst_in_delayslot_i = 1; id_aluop = 8'h21;
        step();
        checks++; if (is_in_delayslot_o !== 1'b1) begin fails++; $display("FAIL bub_dslot_load got %b exp 1", is_in_delayslot_o); end
        next_inst_in_delayslot_i = 0;
        stall = 6'b000100;
        for (int i = 0; i < 3; i++) begin
            step();
            bub_exp++;
            checks++; if (ex_valid !== 1'b0 || ex_aluop !== 8'h0) begin fails++; $display("FAIL bub_zero[%0d] got %b/%h exp 0/0", i, ex_valid, ex_aluop); end
            checks++; if (is_in_delayslot_o !== 1'b1) begin fails++; $display("FAIL bub_dslot[%0d] got %b exp 1", i, is_in_delayslot_o); end
        end
        checks++; if (bubble_cnt !== 4'd3) begin fails++; $display("FAIL bub_cnt got %0d exp 3", bubble_cnt); end
        stall = 0;
    endtask

    task automatic test_hold();
        id_valid = 1; id_reg2 = 32'hA5A5A5A5;
        step();
        checks++; if (ex_reg2 !== 32'hA5A5A5A5) begin fails++; $display("FAIL hold_load got %h exp a5a5a5a5", ex_reg2); end
        id_reg2 = 32'h11111111;
        stall = 6'b001100;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (ex_reg2 !== 32'hA5A5A5A5 || ex_valid !== 1'b1) begin fails++; $display("FAIL hold_keep[%0d] got %h/%b exp a5a5a5a5/1", i, ex_reg2, ex_valid); end
        end
        checks++; if (hold_cnt !== 4'd4) begin fails++; $display("FAIL hold_cnt got %0d exp 4", hold_cnt); end
        checks++; if (bubble_cnt !== 4'(bub_exp)) begin fails++; $display("FAIL hold_bub got %0d exp %0d", bubble_cnt, bub_exp); end
        stall = 0;
    endtask

    task automatic test_flush();
        id_valid = 1; next_inst_in_delayslot_i = 1; id_reg1 = 32'h77;
        step();
        checks++; if (is_in_delayslot_o !== 1'b1 || ex_reg1 !== 32'h77) begin fails++; $display("FAIL fl_setup got %b/%h exp 1/77", is_in_delayslot_o, ex_reg1); end
        flush = 1; stall = 6'b000100;
        step();
        checks++; if (ex_valid !== 1'b0 || ex_reg1 !== 32'h0 || ex_wd !== 5'd0) begin fails++; $display("FAIL fl_bub_zero got %b/%h/%0d exp 0/0/0", ex_valid, ex_reg1, ex_wd); end
        checks++; if (is_in_delayslot_o !== 1'b0) begin fails++; $display("FAIL fl_bub_dslot got %b exp 0", is_in_delayslot_o); end
        checks++; if (bubble_cnt !== 4'(bub_exp)) begin fails++; $display("FAIL fl_bub_cnt got %0d exp %0d", bubble_cnt, bub_exp); end
        stall = 0; id_reg1 = 32'h55;
        step();
        checks++; if (ex_reg1 !== 32'h0 || ex_valid !== 1'b0 || is_in_delayslot_o !== 1'b0) begin fails++; $display("FAIL fl_adv got %h/%b/%b exp 0/0/0", ex_reg1, ex_valid, is_in_delayslot_o); end
        flush = 0;
        step();
        checks++; if (ex_reg1 !== 32'h55 || ex_valid !== 1'b1) begin fails++; $display("FAIL fl_resume got %h/%b exp 55/1", ex_reg1, ex_valid); end
    endtask

    task automatic test_saturation();
        stall = 6'b000100;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bub_exp < 15) bub_exp++;
            checks++; if (bubble_cnt !== 4'(bub_exp)) begin fails++; $display("FAIL sat[%0d] got %0d exp %0d", i, bubble_cnt, bub_exp); end
        end
        rst = 1; flush = 1;
        step();
        checks++; if (bubble_cnt !== 4'd0 || hold_cnt !== 4'd0) begin fails++; $display("FAIL sat_rst got %0d/%0d exp 0/0", bubble_cnt, hold_cnt); end
        rst = 0; flush = 0; stall = 0; id_reg1 = 32'h99;
        step();
        checks++; if (ex_reg1 !== 32'h99 || bubble_cnt !== 4'd0) begin fails++; $display("FAIL sat_resume got %h/%0d exp 99/0", ex_reg1, bubble_cnt); end
    endtask

    initial begin
        test_reset();
        test_advance();
        test_bubble_dslot();
        test_hold();
        test_flush();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised decode/execute pipeline register, successor to the fixed-width ID/EX latch. It sits between the decode stage and the ALU/branch execute stage and adds several behaviours: configurable widths and stall-vector position, an exception flush, and per-entry valid tracking with write-enable gating. It also retains the delay-slot flag across bubbles and keeps saturating counters of inserted bubbles and hold cycles for performance monitoring.

## Interface
Parameters:
- XLEN, 32, data/address width of operand, link and PC fields
- AW, 5, register-file address width
- OPW, 8, aluop width
- SELW, 3, alusel width
- STALLW, 6, stall vector width; requires STAGE+1 < STALLW
- STAGE, 2, stall bit owned by decode; bit STAGE+1 is execute
- EXCW, 32, exception-type field width
- CNTW, 16, perf counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset (1 = reset, sampled on clk rising edge)
- stall  in  STALLW  stall vector from control; 1 = stop
- flush  in  1  exception flush; 1 = discard decode and execute contents
- id_valid  in  1  decode holds a real instruction
- id_aluop / id_alusel  in  OPW / SELW  operation and result select
- id_reg1, id_reg2  in  XLEN  source operands
- id_wd  in  AW  destination register
- id_wreg  in  1  register write enable
- id_link_address  in  XLEN  return address for link branches
- id_is_in_delayslot  in  1  decode instruction is in a delay slot
- next_inst_in_delayslot_i  in  1  next decode instruction is in a delay slot
- id_pc  in  XLEN  decode instruction PC
- id_excepttype  in  EXCW  exception flags from decode
- ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_link_address, ex_is_in_delayslot, ex_pc, ex_excepttype  out  matching widths  registered execute fields
- ex_valid  out  1  execute holds a real instruction
- is_in_delayslot_o  out  1  registered delay-slot flag returned to decode
- bubble_cnt  out  CNTW  bubbles inserted, saturating
- hold_cnt  out  CNTW  cycles held with decode and execute both stalled, saturating

## Operation
- Each rising edge applies exactly one action, chosen by this priority:
  1. **RESET** (rst=1): all outputs and both counters become 0.
  2. **FLUSH** (flush=1): all ex_* fields, ex_valid and is_in_delayslot_o become 0. Counters are unchanged. Flush overrides any stall.
  3. **BUBBLE** (stall[STAGE]=1, stall[STAGE+1]=0): all ex_* fields and ex_valid become 0. is_in_delayslot_o **holds** its value, so a pending delay slot survives a decode stall. bubble_cnt increments.
  4. **ADVANCE** (stall[STAGE]=0): all ex_* fields load their id_* values, ex_valid loads id_valid, and is_in_delayslot_o loads next_inst_in_delayslot_i. If id_valid=0, ex_wreg is forced to 0 and ex_excepttype to 0; the other fields still load.
  5. **HOLD** (stall[STAGE]=1, stall[STAGE+1]=1): all outputs hold. hold_cnt increments.
- The "zero" value is 0 for every field: aluop 0 is NOP, alusel 0 is NOP, wd 0 is $0.
- Counters saturate at 2^CNTW−1 and never wrap. They clear only on rst.
- The case stall[STAGE]=0 with stall[STAGE+1]=1 is illegal from control. The block treats it as ADVANCE; the bench must not rely on it.

## Timing
- Latency: 1 cycle from id_* to ex_* on ADVANCE.
- No combinational path from any input to any output. All outputs are registered.
- rst and flush are sampled only at the clock edge. An rst pulse mid-stall clears state on that edge, and the next edge resumes normal priority.
- Simultaneous flush and bubble: flush wins, so is_in_delayslot_o becomes 0 and bubble_cnt does not increment.
- Simultaneous rst and flush: reset wins, and the counters clear.
- Counter increment and saturation take effect on the same edge as the qualifying condition.

## Test plan
- **Reset:** rst=1 for 2 cycles with id_aluop=0x21 and id_reg1=0xDEADBEEF → every output is 0 and both counters are 0.
- **Advance:** stall=0, id_valid=1, id_reg1=0x12345678, id_wd=5, id_wreg=1 → the next edge gives ex_reg1=0x12345678, ex_wd=5, ex_wreg=1, ex_valid=1. With id_valid=0 and id_wreg=1 → ex_wreg=0 and ex_excepttype=0.
- **Bubble with delay slot:** advance with next_inst_in_delayslot_i=1, then stall=6'b000100 for 3 cycles → ex_valid=0 and ex_aluop=0 each cycle, is_in_delayslot_o stays 1, bubble_cnt=3.
- **Hold:** load ex_reg2=0xA5A5A5A5, then stall=6'b001100 for 4 cycles → ex_reg2 stays 0xA5A5A5A5, hold_cnt=4, bubble_cnt unchanged.
- **Flush priority:** flush=1 together with stall=6'b000100 and is_in_delayslot_o=1 → all outputs become 0 and bubble_cnt is unchanged. flush=1 with stall=0 → id_* values are not loaded.
- **Saturation:** with CNTW=4, apply 20 bubble cycles → bubble_cnt sticks at 15. Then rst=1 → bubble_cnt=0.
